// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding, frame constants and a baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Clock cycles per bit period, truncated toward zero.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and registered
// full/empty/level flags. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    // Accept/pop qualification uses the registered flags, so a write while
    // full is dropped even if a pop frees a slot on the same edge.
    always_comb begin
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        full_d   = (level_d == (AW+1)'(DEPTH));
        empty_d  = (level_d == '0);
    end

    // Pointer and occupancy registers; reset discards any stored bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until pointed to by a valid entry.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8N2 UART transmitter: a byte FIFO feeding an LSB-first
// serializer. uart_tx and tx_done are registered from the current state, so
// the line trails the state register by one cycle and tx_done lands exactly
// on the last cycle of the final stop bit as seen on the pin.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = baud_div(27_000_000, 115_200),
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          uart_tx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic                      fifo_full, fifo_empty;
    logic                      pop;

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;
    logic                      baud_last;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    // Serializer next-state, bit timing and line value for the next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        ovf_d   = wr_en && fifo_full;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_done  = done_q;
    assign uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: stimulus queues expected bytes, a monitor
// decodes frames off the line and compares them against the queue.
module tb_uart_tx_buffered;

    localparam int BD    = 4;
    localparam int DEP   = 4;
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, wr_en_b;
    logic [7:0] wr_data, wr_data_b;
    logic       full, empty, overflow, busy, tx_done, uart_tx;
    logic [2:0] level;
    logic       full_b, empty_b, overflow_b, busy_b, tx_done_b, uart_tx_b;
    logic [2:0] level_b;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int done_total = 0;
    int ov_total = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int starts_q[$];
    int ends_q[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(DEP), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .busy(busy), .tx_done(tx_done), .uart_tx(uart_tx)
    );

    uart_tx_buffered #(.BAUD_DIV(234), .FIFO_DEPTH(DEP), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b),
        .busy(busy_b), .tx_done(tx_done_b), .uart_tx(uart_tx_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while (!(empty === 1'b1 && busy === 1'b0 && uart_tx === 1'b1 && exp_q.size() == 0)
               && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            failures++;
            $display("FAIL %s: still active after %0d cycles, expected idle", name, n);
        end
        repeat (3) step();
    endtask

    always @(posedge clk) ncyc <= ncyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_total <= done_total + 1;
    always @(negedge clk) if (overflow === 1'b1) ov_total <= ov_total + 1;

    // Frame monitor: decodes each frame from its first low cycle.
    initial begin : monitor
        logic [FRAME-1:0] ls;
        logic [7:0] b;
        bit aborted, bad;
        int dcnt, dpos, start_c;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                start_c = ncyc;
                aborted = 0;
                dcnt = 0;
                dpos = -1;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1;
                        break;
                    end
                    ls[k] = uart_tx;
                    if (tx_done === 1'b1) begin
                        dcnt++;
                        dpos = k;
                    end
                end
                if (!aborted) begin
                    bad = 0;
                    for (int bt = 0; bt < 10; bt++)
                        for (int c = 1; c < BD; c++)
                            if (ls[bt*BD+c] !== ls[bt*BD]) bad = 1;
                    chk("bit_hold_width", 32'(bad), 0);
                    chk("start_bit", 32'(ls[0]), 0);
                    chk("stop_bit", 32'(ls[9*BD]), 1);
                    chk("tx_done_count", dcnt, 1);
                    chk("tx_done_pos", dpos, FRAME - 1);
                    for (int i = 0; i < 8; i++) b[i] = ls[(i+1)*BD];
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got 0x%02h expected no frame", b);
                    end else begin
                        chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                    starts_q.push_back(start_c);
                    ends_q.push_back(ncyc);
                    frames++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] hi [4];
        logic [7:0] ovb [5];
        int f0, d0, o0, peak, n, low, high, done_at;
        hi  = '{8'h48, 8'h69, 8'h0D, 8'h0A};
        ovb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_en_b = 1'b0; wr_data_b = '0;
        repeat (3) step();
        chk("rst_uart_tx", 32'(uart_tx), 1);
        chk("rst_tx_done", 32'(tx_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_uart_tx_b", 32'(uart_tx_b), 1);
        rst = 1'b0;
        step();

        // Single byte 0x55 with latency checks
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        step();
        wr_en = 1'b0;
        chk("single_empty_after_push", 32'(empty), 0);
        chk("single_level_after_push", 32'(level), 1);
        chk("single_tx_high_edge1", 32'(uart_tx), 1);
        step();
        chk("single_tx_high_pop_edge", 32'(uart_tx), 1);
        chk("single_busy_after_pop", 32'(busy), 1);
        chk("single_level_after_pop", 32'(level), 0);
        step();
        chk("single_tx_low_2_after_push", 32'(uart_tx), 0);
        d0 = done_total;
        wait_idle("single_idle", 200);
        chk("single_done_pulses", done_total - d0, 1);
        chk("single_busy_after", 32'(busy), 0);

        // Push coinciding with the IDLE pop at level 1
        f0 = frames;
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        chk("pp_level_first", 32'(level), 1);
        wr_data = 8'h3C; exp_q.push_back(8'h3C);
        step();
        wr_en = 1'b0;
        chk("pp_level_push_pop", 32'(level), 1);
        wait_idle("pp_idle", 300);
        chk("pp_frames", frames - f0, 2);

        // Burst "Hi\r\n"
        f0 = frames; d0 = done_total; peak = 0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = hi[i]; exp_q.push_back(hi[i]);
            step();
            if (int'(level) > peak) peak = int'(level);
        end
        wr_en = 1'b0;
        chk("burst_level_peak", peak, 3);
        wait_idle("burst_idle", 600);
        chk("burst_frames", frames - f0, 4);
        chk("burst_done_pulses", done_total - d0, 4);
        if (frames - f0 == 4) begin
            for (int i = 0; i < 3; i++)
                chk("burst_gap", starts_q[f0+i+1] - ends_q[f0+i], 2);
            for (int i = 0; i < 4; i++)
                chk("burst_frame_len", ends_q[f0+i] - starts_q[f0+i] + 1, FRAME);
        end

        // Overflow with FIFO full and a frame in flight
        o0 = ov_total;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = ovb[i]; exp_q.push_back(ovb[i]);
            step();
        end
        chk("ovf_full_before", 32'(full), 1);
        chk("ovf_level_before", 32'(level), 4);
        chk("ovf_busy", 32'(busy), 1);
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_level_after", 32'(level), 4);
        step();
        chk("ovf_pulse_end", 32'(overflow), 0);
        wait_idle("ovf_idle", 800);
        chk("ovf_pulse_count", ov_total - o0, 1);

        // Reset during DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("rstmid_start_seen", 32'(n < 20), 1);
        repeat (BD + 3*BD + 1) step();
        chk("rstmid_level_before", 32'(level), 2);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        step();
        rst = 1'b0; wr_en = 1'b0;
        chk("rstmid_uart_tx", 32'(uart_tx), 1);
        chk("rstmid_empty", 32'(empty), 1);
        chk("rstmid_level", 32'(level), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_tx_done", 32'(tx_done), 0);
        d0 = done_total; f0 = frames;
        repeat (120) step();
        chk("rstmid_no_done", done_total - d0, 0);
        chk("rstmid_no_frames", frames - f0, 0);
        chk("rstmid_line_idle", 32'(uart_tx), 1);

        // Two stop bits at BAUD_DIV=234, byte 0x00
        wr_en_b = 1'b1; wr_data_b = 8'h00;
        step();
        wr_en_b = 1'b0;
        n = 0;
        while (uart_tx_b !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        low = 0;
        while (uart_tx_b === 1'b0 && low < 3000) begin
            low++;
            step();
        end
        chk("stop2_low_cycles", low, 9 * 234);
        high = 0; done_at = 0;
        while (done_at == 0 && high < 1000) begin
            high++;
            if (tx_done_b === 1'b1) done_at = high;
            else begin
                if (uart_tx_b !== 1'b1) high = 1000;
                step();
            end
        end
        chk("stop2_done_at_high_cycle", done_at, 2 * 234);
        chk("stop2_line_at_done", 32'(uart_tx_b), 1);
        step();
        chk("stop2_done_end", 32'(tx_done_b), 0);
        chk("stop2_busy_end", 32'(busy_b), 0);

        chk("expected_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
